// File: rtl/wb_select_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_select_stage
// Description : Registered writeback stage. Selects one of NSRC results or
//               load data, holds a load until data returns, drives the
//               register-file write port and counts WAIT stall cycles.
//               Optional build macro WB_LOAD_EXT_EN adds sub-word load
//               extraction (in_ldtype / in_boff).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_select_stage #(
    parameter int DW   = 32,
    parameter int NSRC = 4,
    parameter int SELW = 2,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_sel,
    input  logic [NSRC*DW-1:0]   in_src,
    input  logic                 in_mem,
    input  logic                 in_we,
    input  logic [AW-1:0]        in_wa,
`ifdef WB_LOAD_EXT_EN
    input  logic [2:0]           in_ldtype,
    input  logic [1:0]           in_boff,
`endif
    input  logic                 mem_valid,
    input  logic [DW-1:0]        mem_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [DW-1:0]        rf_wd,
    output logic [CNTW-1:0]      stall_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] c_cnt_max = '1;

    state_t          r_state;
    logic            r_pend_we;
    logic [AW-1:0]   r_pend_wa;
    logic [DW-1:0]   w_src;
    logic [DW-1:0]   w_mem_now;
    logic [DW-1:0]   w_mem_pend;
    logic            w_accept;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_src = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                w_src = in_src[k*DW +: DW];
            end
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [2:0] r_pend_ldtype;
    logic [1:0] r_pend_boff;

    function automatic logic [DW-1:0] f_load_ext(
        input logic [DW-1:0] d,
        input logic [2:0]    t,
        input logic [1:0]    off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (t)
            3'd1:    f_load_ext = {{(DW-8){b[7]}}, b};
            3'd2:    f_load_ext = {{(DW-8){1'b0}}, b};
            3'd3:    f_load_ext = {{(DW-16){h[15]}}, h};
            3'd4:    f_load_ext = {{(DW-16){1'b0}}, h};
            default: f_load_ext = d;
        endcase
    endfunction

    assign w_mem_now  = f_load_ext(mem_data, in_ldtype, in_boff);
    assign w_mem_pend = f_load_ext(mem_data, r_pend_ldtype, r_pend_boff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_ldtype <= '0;
            r_pend_boff   <= '0;
        end else if (w_accept && in_mem && !mem_valid) begin
            r_pend_ldtype <= in_ldtype;
            r_pend_boff   <= in_boff;
        end
    end
`else
    assign w_mem_now  = mem_data;
    assign w_mem_pend = mem_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pend_we <= 1'b0;
            r_pend_wa <= '0;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            stall_cnt <= '0;
        end else begin
            rf_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!in_mem || mem_valid) begin
                            rf_we <= in_we && (in_wa != '0);
                            rf_wa <= in_wa;
                            rf_wd <= in_mem ? w_mem_now : w_src;
                        end else begin
                            r_pend_we <= in_we;
                            r_pend_wa <= in_wa;
                            r_state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        rf_we   <= r_pend_we && (r_pend_wa != '0);
                        rf_wa   <= r_pend_wa;
                        rf_wd   <= w_mem_pend;
                        r_state <= ST_IDLE;
                    end else if (stall_cnt != c_cnt_max) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_select_stage
// Description : Randomized self-checking bench for wb_select_stage with an
//               op-level reference model (NSRC=3 so out-of-range selects occur).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_select_stage;

    localparam int DW   = 32;
    localparam int NSRC = 3;
    localparam int SELW = 2;
    localparam int AW   = 5;
    localparam int CNTW = 12;
    localparam int CMAX = (1 << CNTW) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [SELW-1:0]     in_sel = '0;
    logic [NSRC*DW-1:0]  in_src = '0;
    logic                in_mem = 1'b0;
    logic                in_we = 1'b0;
    logic [AW-1:0]       in_wa = '0;
    logic [2:0]          in_ldtype = '0;
    logic [1:0]          in_boff = '0;
    logic                mem_valid = 1'b0;
    logic [DW-1:0]       mem_data = '0;
    logic                rf_we;
    logic [AW-1:0]       rf_wa;
    logic [DW-1:0]       rf_wd;
    logic [CNTW-1:0]     stall_cnt;

    int vecs = 0;
    int errs = 0;

    // Model state: last committed address/data and the stall count.
    logic [AW-1:0] exp_wa  = '0;
    logic [DW-1:0] exp_wd  = '0;
    int            exp_cnt = 0;

    wb_select_stage #(
        .DW(DW), .NSRC(NSRC), .SELW(SELW), .AW(AW), .CNTW(CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_src    (in_src),
        .in_mem    (in_mem),
        .in_we     (in_we),
        .in_wa     (in_wa),
`ifdef WB_LOAD_EXT_EN
        .in_ldtype (in_ldtype),
        .in_boff   (in_boff),
`endif
        .mem_valid (mem_valid),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] m_load(input logic [DW-1:0] md,
                                             input logic [2:0] lt,
                                             input logic [1:0] bo);
        logic [DW-1:0] s;
        logic [DW-1:0] r;
        r = md;
`ifdef WB_LOAD_EXT_EN
        if (lt == 3'd1 || lt == 3'd2) s = md >> (int'(bo) * 8);
        else                          s = md >> (int'(bo[1]) * 16);
        if (lt == 3'd1)      r = 32'(signed'(s[7:0]));
        else if (lt == 3'd2) r = s & 32'h0000_00FF;
        else if (lt == 3'd3) r = 32'(signed'(s[15:0]));
        else if (lt == 3'd4) r = s & 32'h0000_FFFF;
`else
        s = {29'd0, lt} ^ {30'd0, bo};
        if (s == 32'hFFFF_FFFF) r = md;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op from accept to commit; delay = cycles from accept to mem_valid.
    task automatic run_op(input string nm, input bit mem, input logic [SELW-1:0] sel,
                          input logic [NSRC*DW-1:0] src, input bit we,
                          input logic [AW-1:0] wa, input int delay,
                          input logic [DW-1:0] md, input logic [2:0] lt,
                          input logic [1:0] bo);
        logic [DW-1:0] ed;
        logic          ewe;
        ed  = mem ? m_load(md, lt, bo) : ((int'(sel) < NSRC) ? src[int'(sel)*DW +: DW] : '0);
        ewe = we && (wa != 0);
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++; $display("FAIL %s ready_before_accept: got %b want 1", nm, in_ready);
        end
        in_valid  = 1'b1; in_mem = mem; in_sel = sel; in_src = src;
        in_we     = we;   in_wa  = wa;  in_ldtype = lt; in_boff = bo;
        mem_valid = mem && (delay == 0);
        mem_data  = (mem && delay == 0) ? md : DW'($urandom);
        tick();
        in_valid  = 1'b0;
        in_ldtype = 3'($urandom); in_boff = 2'($urandom);
        if (mem) begin
            for (int i = 1; i <= delay; i++) begin
                vecs++;
                if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
                    errs++;
                    $display("FAIL %s wait_cycle%0d: ready=%b we=%b want 0 0", nm, i, in_ready, rf_we);
                end
                mem_valid = (i == delay);
                mem_data  = (i == delay) ? md : DW'($urandom);
                if (i < delay && exp_cnt < CMAX) exp_cnt++;
                tick();
            end
        end
        mem_valid = 1'b0;
        vecs++;
        if (rf_we !== ewe || rf_wa !== wa || rf_wd !== ed || stall_cnt !== CNTW'(exp_cnt)) begin
            errs++;
            $display("FAIL %s commit: we=%b wa=%0d wd=%h cnt=%0d want we=%b wa=%0d wd=%h cnt=%0d",
                     nm, rf_we, rf_wa, rf_wd, stall_cnt, ewe, wa, ed, exp_cnt);
        end
        exp_wa = wa;
        exp_wd = ed;
    endtask

    task automatic idle_cycle(input string nm);
        in_valid  = 1'b0;
        mem_valid = 1'($urandom);
        mem_data  = DW'($urandom);
        tick();
        mem_valid = 1'b0;
        vecs++;
        if (rf_we !== 1'b0 || rf_wa !== exp_wa || rf_wd !== exp_wd ||
            stall_cnt !== CNTW'(exp_cnt) || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s idle_hold: we=%b wa=%0d wd=%h cnt=%0d rdy=%b want 0 %0d %h %0d 1",
                     nm, rf_we, rf_wa, rf_wd, stall_cnt, in_ready, exp_wa, exp_wd, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vecs++;
        if (rf_we !== 1'b0 || rf_wa !== '0 || rf_wd !== '0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_values: we=%b wa=%0d wd=%h cnt=%0d rdy=%b want 0 0 0 0 1",
                     rf_we, rf_wa, rf_wd, stall_cnt, in_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        exp_wa = '0; exp_wd = '0; exp_cnt = 0;
        idle_cycle("post_reset");
    endtask

    task automatic test_basic();
        logic [NSRC*DW-1:0] s;
        s = {32'hAAAA_0002, 32'h0000_1234, 32'h5555_0000};
        run_op("basic", 1'b0, 2'd1, s, 1'b1, 5'd5, 0, '0, 3'd0, 2'd0);
        idle_cycle("basic_after");
    endtask

    task automatic test_reg0_back_to_back();
        logic [NSRC*DW-1:0] s;
        s = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        run_op("reg0", 1'b0, 2'd0, s, 1'b1, 5'd0, 0, '0, 3'd0, 2'd0);
        run_op("b2b_r1", 1'b0, 2'd0, s, 1'b1, 5'd1, 0, '0, 3'd0, 2'd0);
        run_op("b2b_r2", 1'b0, 2'd1, s, 1'b1, 5'd2, 0, '0, 3'd0, 2'd0);
        run_op("b2b_r3", 1'b0, 2'd2, s, 1'b1, 5'd3, 0, '0, 3'd0, 2'd0);
        run_op("reg0_mem", 1'b1, 2'd0, s, 1'b1, 5'd0, 0, 32'h0BAD_0BAD, 3'd0, 2'd0);
        idle_cycle("b2b_after");
    endtask

    task automatic test_mem_wait();
        int c0;
        c0 = exp_cnt;
        run_op("mem_wait", 1'b1, 2'd0, '0, 1'b1, 5'd7, 3, 32'hDEAD_BEEF, 3'd0, 2'd0);
        vecs++;
        if (int'(stall_cnt) - c0 !== 2) begin
            errs++; $display("FAIL mem_wait_stalls: got %0d want 2", int'(stall_cnt) - c0);
        end
        run_op("mem_same_cycle", 1'b1, 2'd2, '0, 1'b1, 5'd8, 0, 32'hCAFE_F00D, 3'd0, 2'd0);
        run_op("mem_we0", 1'b1, 2'd0, '0, 1'b0, 5'd9, 1, 32'h1357_9BDF, 3'd0, 2'd0);
        idle_cycle("mem_after");
    endtask

    task automatic test_sel_oob();
        run_op("sel_oob", 1'b0, 2'd3, {3{32'hFFFF_FFFF}}, 1'b1, 5'd12, 0, '0, 3'd0, 2'd0);
    endtask

    task automatic test_load_ext();
`ifdef WB_LOAD_EXT_EN
        run_op("lb_b0",  1'b1, 2'd0, '0, 1'b1, 5'd10, 0, 32'h80FF_7F80, 3'd1, 2'd0);
        run_op("lbu_b1", 1'b1, 2'd0, '0, 1'b1, 5'd11, 2, 32'h80FF_7F80, 3'd2, 2'd1);
        run_op("lh_b2",  1'b1, 2'd0, '0, 1'b1, 5'd12, 1, 32'h80FF_7F80, 3'd3, 2'd2);
        run_op("lhu_b2", 1'b1, 2'd0, '0, 1'b1, 5'd13, 0, 32'h80FF_7F80, 3'd4, 2'd2);
        run_op("code6",  1'b1, 2'd0, '0, 1'b1, 5'd14, 1, 32'h80FF_7F80, 3'd6, 2'd3);
`else
        run_op("lw_raw", 1'b1, 2'd0, '0, 1'b1, 5'd10, 1, 32'h80FF_7F80, 3'd1, 2'd1);
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            run_op("rand", ($urandom_range(0, 2) == 0), SELW'($urandom),
                   {32'($urandom), 32'($urandom), 32'($urandom)}, 1'($urandom),
                   ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom),
                   $urandom_range(0, 4), 32'($urandom), 3'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
        end
    endtask

    task automatic test_saturate();
        run_op("saturate", 1'b1, 2'd0, '0, 1'b1, 5'd21, (1 << CNTW) + 6,
               32'h0F0F_0F0F, 3'd0, 2'd0);
        vecs++;
        if (stall_cnt !== CNTW'(CMAX)) begin
            errs++; $display("FAIL saturate_value: got %h want %h", stall_cnt, CNTW'(CMAX));
        end
        run_op("after_sat", 1'b1, 2'd0, '0, 1'b1, 5'd22, 2, 32'h1234_5678, 3'd0, 2'd0);
    endtask

    task automatic test_reset_wait();
        in_valid = 1'b1; in_mem = 1'b1; in_we = 1'b1; in_wa = 5'd9; mem_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        vecs++;
        if (rf_we !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== '0) begin
            errs++;
            $display("FAIL reset_in_wait: we=%b rdy=%b cnt=%0d want 0 1 0", rf_we, in_ready, stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        exp_wa = '0; exp_wd = '0; exp_cnt = 0;
        mem_valid = 1'b1; mem_data = 32'hBADD_CAFE;
        tick();
        mem_valid = 1'b0;
        vecs++;
        if (rf_we !== 1'b0 || in_ready !== 1'b1 || rf_wd !== '0) begin
            errs++;
            $display("FAIL aborted_op_write: we=%b rdy=%b wd=%h want 0 1 0", rf_we, in_ready, rf_wd);
        end
        run_op("pre_commit_reset", 1'b0, 2'd0, {3{32'h7777_7777}}, 1'b1, 5'd4, 0, '0, 3'd0, 2'd0);
        rst_n = 1'b0;
        #1;
        vecs++;
        if (rf_we !== 1'b0 || rf_wd !== '0) begin
            errs++; $display("FAIL reset_on_commit: we=%b wd=%h want 0 0", rf_we, rf_wd);
        end
        tick();
        rst_n = 1'b1;
        exp_wa = '0; exp_wd = '0; exp_cnt = 0;
        idle_cycle("after_reset_commit");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reg0_back_to_back();
        test_mem_wait();
        test_sel_oob();
        test_load_ext();
        test_random();
        test_saturate();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
